// File: rtl/operand_loader.sv
// Operand loader: takes a job command, fills vector A/B (and the ternary matrix for
// COMP_MUL) from a word stream, then starts the compute stage and holds operands until done.
package accel_pkg;
  localparam int VECTOR_WIDTH = 16;
  localparam int MATRIX_DEPTH = 4;
  localparam int VECTOR_LEN   = 16;

  typedef enum logic [1:0] {
    COMP_ADD = 2'd0,
    COMP_SUB = 2'd1,
    COMP_MUL = 2'd2,
    COMP_DOT = 2'd3
  } computation_type_t;

  typedef struct packed {
    logic [VECTOR_LEN-1:0][VECTOR_WIDTH-1:0] data;
  } vector_data_t;

  // Each row packs MATRIX_DEPTH 2-bit entries: bit 0 = enable, bit 1 = negate.
  typedef struct packed {
    logic [VECTOR_LEN-1:0][2*MATRIX_DEPTH-1:0] rows;
  } matrix_data_t;
endpackage

module operand_loader
  import accel_pkg::*;
#(
  parameter int N = 16,
  parameter int W = VECTOR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  computation_type_t cmd_type,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              in_last,
  output computation_type_t comp_type,
  output vector_data_t      vector_a,
  output vector_data_t      vector_b,
  output matrix_data_t      matrix_out,
  output logic              start,
  input  logic              done,
  output logic              loader_busy,
  output logic              protocol_err
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_M, START, WAIT} state_t;

  state_t       state, state_next;
  logic [3:0]   idx;
  logic         loading, accept, last_idx, early_end, phase_end, cmd_take;
  logic [N-1:0] wr_sel, clr_sel;

  assign loading   = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_M);
  assign accept    = in_valid && loading;
  assign last_idx  = (idx == 4'(N-1));
  assign early_end = accept && in_last && !last_idx;
  assign phase_end = accept && (in_last || last_idx);
  assign cmd_take  = cmd_valid && (state == IDLE);

  // An early in_last zeroes every element above the one being written.
  always_comb begin
    wr_sel  = '0;
    clr_sel = '0;
    for (int k = 0; k < N; k++) begin
      wr_sel[k]  = accept && (4'(k) == idx);
      clr_sel[k] = early_end && (4'(k) > idx);
    end
  end

  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    start       = 1'b0;
    loader_busy = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready   = 1'b1;
        loader_busy = 1'b0;
        if (cmd_valid) state_next = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (phase_end) state_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (phase_end) state_next = (comp_type == COMP_MUL) ? LOAD_M : START;
      end
      LOAD_M: begin
        in_ready = 1'b1;
        if (phase_end) state_next = START;
      end
      START: begin
        start      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand buffers only move on a word accept or a command handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      comp_type    <= COMP_ADD;
      vector_a     <= '0;
      vector_b     <= '0;
      matrix_out   <= '0;
      protocol_err <= 1'b0;
    end else begin
      protocol_err <= accept && (last_idx ? !in_last : in_last);
      if (cmd_take) begin
        comp_type <= cmd_type;
        idx       <= '0;
      end else if (accept) begin
        idx <= phase_end ? 4'd0 : idx + 4'd1;
      end
      for (int k = 0; k < N; k++) begin
        if (wr_sel[k] || clr_sel[k]) begin
          case (state)
            LOAD_A:  vector_a.data[k]   <= wr_sel[k] ? in_data : '0;
            LOAD_B:  vector_b.data[k]   <= wr_sel[k] ? in_data : '0;
            LOAD_M:  matrix_out.rows[k] <= wr_sel[k] ? in_data[2*MATRIX_DEPTH-1:0] : '0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: expected operands are queued as each job is
// driven and compared when start fires.
module tb_operand_loader;
  import accel_pkg::*;

  localparam int N  = 16;
  localparam int W  = VECTOR_WIDTH;
  localparam int MW = 2 * MATRIX_DEPTH;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  computation_type_t cmd_type;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              in_last;
  computation_type_t comp_type;
  vector_data_t      vector_a;
  vector_data_t      vector_b;
  matrix_data_t      matrix_out;
  logic              start;
  logic              done;
  logic              loader_busy;
  logic              protocol_err;

  operand_loader #(.N(N), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .comp_type    (comp_type),
    .vector_a     (vector_a),
    .vector_b     (vector_b),
    .matrix_out   (matrix_out),
    .start        (start),
    .done         (done),
    .loader_busy  (loader_busy),
    .protocol_err (protocol_err)
  );

  typedef struct {
    computation_type_t t;
    vector_data_t      a;
    vector_data_t      b;
    matrix_data_t      m;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         last_exp;
  logic [W-1:0] a_w[N];
  logic [W-1:0] b_w[N];
  logic [W-1:0] m_w[N];
  matrix_data_t model_m;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   last_lat = 0;
  int   start_cnt = 0;
  int   err_cnt = 0;
  logic start_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake cycle index, sampled at the edge that performs it.
  initial forever begin
    @(posedge clk);
    if (rst_n && cmd_valid && cmd_ready) hs_cyc = cyc;
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (protocol_err) err_cnt++;
      if (start) begin
        start_cnt++;
        last_lat = cyc - hs_cyc;
        chk("start_width", start_prev, 1'b0);
        chk("sb_pending", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          last_exp = sb_q.pop_front();
          chk("sb_comp_type", comp_type, last_exp.t);
          chk("sb_vector_a", vector_a, last_exp.a);
          chk("sb_vector_b", vector_b, last_exp.b);
          chk("sb_matrix", matrix_out, last_exp.m);
        end
      end
      start_prev = start;
    end else begin
      start_prev = 1'b0;
    end
  end

  task automatic expect_job(input computation_type_t t, input int la, input int lb, input int lm);
    exp_t e;
    e.t = t;
    for (int i = 0; i < N; i++) begin
      e.a.data[i] = (i < la) ? a_w[i] : '0;
      e.b.data[i] = (i < lb) ? b_w[i] : '0;
      if (t == COMP_MUL) model_m.rows[i] = (i < lm) ? m_w[i][MW-1:0] : '0;
    end
    e.m = model_m;
    sb_q.push_back(e);
  endtask

  task automatic send_cmd(input computation_type_t t);
    int n = 0;
    cmd_type  = t;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_timeout", n < 200, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic last, input int gap_pct);
    int n = 0;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_last  = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", n < 200, 1'b1);
    @(negedge clk);
  endtask

  task automatic send_phase(input int sel, input int len, input bit last, input int gap_pct,
                            input int done_at);
    logic [W-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = (sel == 0) ? a_w[i] : (sel == 1) ? b_w[i] : m_w[i];
      if (i == done_at) done = 1'b1;
      send_word(d, last && (i == len - 1), gap_pct);
      done = 1'b0;
    end
  endtask

  task automatic stream(input computation_type_t t, input int la, input int lb, input int lm,
                        input bit lasta, input bit lastb, input bit lastm, input int gap_pct,
                        input int done_at_b);
    send_phase(0, la, lasta, gap_pct, -1);
    send_phase(1, lb, lastb, gap_pct, done_at_b);
    if (t == COMP_MUL) send_phase(2, lm, lastm, gap_pct, -1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_start(input int s0);
    int n = 0;
    while (start_cnt == s0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("start_timeout", start_cnt != s0, 1'b1);
  endtask

  task automatic finish_job(input int s0, input int hold, input bit junk);
    wait_start(s0);
    repeat (hold) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
      end
      @(negedge clk);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_busy", loader_busy, 1'b1);
      chk("hold_vector_a", vector_a, last_exp.a);
      chk("hold_vector_b", vector_b, last_exp.b);
      chk("hold_matrix", matrix_out, last_exp.m);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_busy", loader_busy, 1'b0);
    chk("start_once", start_cnt - s0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s0, e0;
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = COMP_ADD;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    done      = 1'b0;
    model_m   = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_busy", loader_busy, 1'b0);
    chk("rst_perr", protocol_err, 1'b0);
    chk("rst_buffers", {vector_a, vector_b}, '0);
    chk("rst_matrix", matrix_out, '0);
    chk("rst_comp_type", comp_type, COMP_ADD);
    rst_n = 1'b1;
    @(negedge clk);

    // Add job at full rate
    for (int i = 0; i < N; i++) begin
      a_w[i] = W'(i + 1);
      b_w[i] = W'(N - i);
    end
    s0 = start_cnt; e0 = err_cnt;
    expect_job(COMP_ADD, N, N, 0);
    send_cmd(COMP_ADD);
    chk("add_in_ready", in_ready, 1'b1);
    stream(COMP_ADD, N, N, 0, 1, 1, 1, 0, -1);
    finish_job(s0, 2, 0);
    chk("add_latency", last_lat, 33);
    chk("add_a0", vector_a.data[0], 16'd1);
    chk("add_b0", vector_b.data[0], 16'd16);
    chk("add_perr", err_cnt - e0, 0);

    // MUL job, enable pattern with junk upper bits, done held off 20 cycles
    for (int i = 0; i < N; i++) begin
      a_w[i] = W'($urandom);
      b_w[i] = W'($urandom);
      m_w[i] = {8'($urandom), 8'h55};
    end
    s0 = start_cnt; e0 = err_cnt;
    expect_job(COMP_MUL, N, N, N);
    send_cmd(COMP_MUL);
    stream(COMP_MUL, N, N, N, 1, 1, 1, 0, -1);
    finish_job(s0, 20, 1);
    chk("mul_latency", last_lat, 49);
    chk("mul_row7", matrix_out.rows[7], 8'h55);
    chk("mul_perr", err_cnt - e0, 0);

    // Early last on A word 5; matrix must stay stale for a non-MUL job
    for (int i = 0; i < N; i++) begin
      a_w[i] = W'(16'h100 + i);
      b_w[i] = W'(16'h200 + i);
    end
    s0 = start_cnt; e0 = err_cnt;
    expect_job(COMP_SUB, 5, N, 0);
    send_cmd(COMP_SUB);
    stream(COMP_SUB, 5, N, 0, 1, 1, 1, 0, -1);
    finish_job(s0, 2, 0);
    chk("early_perr", err_cnt - e0, 1);
    chk("early_a5", vector_a.data[5], 16'd0);
    chk("early_b0", vector_b.data[0], 16'h200);

    // Missing last on B word 16
    for (int i = 0; i < N; i++) begin
      a_w[i] = W'($urandom);
      b_w[i] = W'($urandom);
    end
    s0 = start_cnt; e0 = err_cnt;
    expect_job(COMP_DOT, N, N, 0);
    send_cmd(COMP_DOT);
    stream(COMP_DOT, N, N, 0, 1, 0, 1, 0, -1);
    finish_job(s0, 2, 0);
    chk("nolast_perr", err_cnt - e0, 1);

    // Backpressure, done during LOAD_B, cmd_valid held in WAIT
    for (int i = 0; i < N; i++) begin
      a_w[i] = W'($urandom);
      b_w[i] = W'($urandom);
      m_w[i] = W'($urandom);
    end
    s0 = start_cnt; e0 = err_cnt;
    expect_job(COMP_MUL, N, N, N);
    send_cmd(COMP_MUL);
    stream(COMP_MUL, N, N, N, 1, 1, 1, 30, 5);
    wait_start(s0);
    cmd_type  = COMP_ADD;
    cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("wait_cmd_ready", cmd_ready, 1'b0);
      chk("wait_comp_type", comp_type, COMP_MUL);
    end
    for (int i = 0; i < N; i++) begin
      a_w[i] = W'($urandom);
      b_w[i] = W'($urandom);
    end
    expect_job(COMP_ADD, N, N, 0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("post_done_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("second_comp_type", comp_type, COMP_ADD);
    chk("second_in_ready", in_ready, 1'b1);
    stream(COMP_ADD, N, N, 0, 1, 1, 1, 20, -1);
    finish_job(s0 + 1, 2, 0);
    chk("bp_perr", err_cnt - e0, 0);

    // Reset in LOAD_M after word 8
    for (int i = 0; i < N; i++) begin
      a_w[i] = W'($urandom);
      b_w[i] = W'($urandom);
      m_w[i] = W'($urandom);
    end
    s0 = start_cnt;
    send_cmd(COMP_MUL);
    send_phase(0, N, 1, 0, -1);
    send_phase(1, N, 1, 0, -1);
    send_phase(2, 8, 0, 0, -1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", loader_busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_start", start, 1'b0);
    chk("mid_rst_buffers", {vector_a, vector_b}, '0);
    chk("mid_rst_matrix", matrix_out, '0);
    sb_q.delete();
    model_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_start", start_cnt - s0, 0);

    for (int i = 0; i < N; i++) begin
      a_w[i] = W'(i * 3);
      b_w[i] = W'(i * 5 + 1);
    end
    s0 = start_cnt; e0 = err_cnt;
    expect_job(COMP_ADD, N, N, 0);
    send_cmd(COMP_ADD);
    stream(COMP_ADD, N, N, 0, 1, 1, 1, 0, -1);
    finish_job(s0, 2, 0);
    chk("fresh_latency", last_lat, 33);
    chk("fresh_perr", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
